// File: rtl/board_io_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : board_io_ctrl
// Description : Board timing and display controller. Generates a CPU
//               clock-enable (free-running or single-stepped while halted),
//               debounces the stop/step inputs and scans an N-digit
//               multiplexed hex display from a per-frame snapshot.
// Revision    : 1.0 - initial release
// ============================================================================
module board_io_ctrl #(
  parameter int DIGITS   = 8,
  parameter int SCAN_DIV = 100000,
  parameter int CPU_DIV  = 50,
  parameter int DEB_CYC  = 1000000
) (
  input  logic                  clk_board,
  input  logic                  rst,
  input  logic                  stop,
  input  logic                  step_btn,
  input  logic                  blank_lz,
  input  logic [4*DIGITS-1:0]   in_data,
  input  logic [DIGITS-1:0]     dp_in,
  output logic                  cpu_tick,
  output logic                  halted,
  output logic [31:0]           tick_count,
  output logic [6:0]            display_data,
  output logic                  display_dp,
  output logic [DIGITS-1:0]     display_en
);

  localparam int c_DEB_W = $clog2(DEB_CYC);
  localparam int c_CPU_W = (CPU_DIV > 1) ? $clog2(CPU_DIV) : 1;
  localparam int c_PRE_W = $clog2(SCAN_DIV);
  localparam int c_IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [c_DEB_W-1:0] c_DEB_LAST = c_DEB_W'(DEB_CYC - 1);
  localparam logic [c_CPU_W-1:0] c_CPU_LAST = c_CPU_W'(CPU_DIV - 1);
  localparam logic [c_PRE_W-1:0] c_PRE_LAST = c_PRE_W'(SCAN_DIV - 1);
  localparam logic [c_IDX_W-1:0] c_IDX_LAST = c_IDX_W'(DIGITS - 1);

  // --------------------------------------------------------------------------
  // Debouncers
  // --------------------------------------------------------------------------
  logic               r_stop_db;
  logic [c_DEB_W-1:0] r_stop_cnt;
  logic               r_step_db;
  logic [c_DEB_W-1:0] r_step_cnt;
  logic               w_stop_flip;
  logic               w_step_flip;

  assign w_stop_flip = (stop != r_stop_db) && (r_stop_cnt == c_DEB_LAST);
  assign w_step_flip = (step_btn != r_step_db) && (r_step_cnt == c_DEB_LAST);

  // Stop level follows the raw switch only after DEB_CYC consecutive differing samples
  always_ff @(posedge clk_board) begin
    if (rst) begin
      r_stop_db  <= 1'b1;
      r_stop_cnt <= '0;
    end else if (stop == r_stop_db) begin
      r_stop_cnt <= '0;
    end else if (w_stop_flip) begin
      r_stop_db  <= ~r_stop_db;
      r_stop_cnt <= '0;
    end else begin
      r_stop_cnt <= r_stop_cnt + c_DEB_W'(1);
    end
  end

  // Step level follows the raw button only after DEB_CYC consecutive differing samples
  always_ff @(posedge clk_board) begin
    if (rst) begin
      r_step_db  <= 1'b0;
      r_step_cnt <= '0;
    end else if (step_btn == r_step_db) begin
      r_step_cnt <= '0;
    end else if (w_step_flip) begin
      r_step_db  <= ~r_step_db;
      r_step_cnt <= '0;
    end else begin
      r_step_cnt <= r_step_cnt + c_DEB_W'(1);
    end
  end

  // --------------------------------------------------------------------------
  // Tick generator
  // --------------------------------------------------------------------------
  logic               r_step_d;
  logic [c_CPU_W-1:0] r_div;
  logic               r_tick;
  logic [31:0]        r_tick_cnt;
  logic               w_step_rise;
  logic               w_release;
  logic               w_tick_nxt;

  assign w_step_rise = r_step_db & ~r_step_d;
  // A halt release in this cycle suppresses a coincident step tick
  assign w_release   = r_stop_db & w_stop_flip;
  assign w_tick_nxt  = (~r_stop_db & (r_div == c_CPU_LAST)) |
                       (w_step_rise & r_stop_db & ~w_release);

  // Divider held at zero while halted so the first free-run tick lands CPU_DIV cycles after release
  always_ff @(posedge clk_board) begin
    if (rst) begin
      r_step_d   <= 1'b0;
      r_div      <= '0;
      r_tick     <= 1'b0;
      r_tick_cnt <= '0;
    end else begin
      r_step_d <= r_step_db;
      if (r_stop_db || (r_div == c_CPU_LAST)) begin
        r_div <= '0;
      end else begin
        r_div <= r_div + c_CPU_W'(1);
      end
      r_tick <= w_tick_nxt;
      if (w_tick_nxt) begin
        r_tick_cnt <= r_tick_cnt + 32'd1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Scanner
  // --------------------------------------------------------------------------
  logic [c_PRE_W-1:0]  r_pre;
  logic [c_IDX_W-1:0]  r_idx;
  logic [4*DIGITS-1:0] r_snap_data;
  logic [DIGITS-1:0]   r_snap_dp;
  logic                r_snap_blank;

  // Prescaler advances the digit index; the snapshot is refreshed only as a new frame starts
  always_ff @(posedge clk_board) begin
    if (rst) begin
      r_pre        <= '0;
      r_idx        <= '0;
      r_snap_data  <= '0;
      r_snap_dp    <= '0;
      r_snap_blank <= 1'b0;
    end else if (r_pre == c_PRE_LAST) begin
      r_pre <= '0;
      if (r_idx == c_IDX_LAST) begin
        r_idx        <= '0;
        r_snap_data  <= in_data;
        r_snap_dp    <= dp_in;
        r_snap_blank <= blank_lz;
      end else begin
        r_idx <= r_idx + c_IDX_W'(1);
      end
    end else begin
      r_pre <= r_pre + c_PRE_W'(1);
    end
  end

  logic [3:0]        w_nib;
  logic              w_dp_sel;
  logic              w_zero_up;
  logic              w_acc;
  logic [DIGITS-1:0] w_en_n;
  logic              w_blank;
  logic [6:0]        w_seg;

  // Select the scanned digit and track whether it and all digits above it are zero
  always_comb begin
    w_nib     = 4'h0;
    w_dp_sel  = 1'b0;
    w_zero_up = 1'b0;
    w_acc     = 1'b1;
    w_en_n    = '1;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      w_acc = w_acc && (r_snap_data[4*i +: 4] == 4'h0);
      if (r_idx == c_IDX_W'(i)) begin
        w_nib     = r_snap_data[4*i +: 4];
        w_dp_sel  = r_snap_dp[i];
        w_zero_up = w_acc;
        w_en_n[i] = 1'b0;
      end
    end
  end

  assign w_blank = r_snap_blank && (r_idx != '0) && w_zero_up;

  // Active-low hex to {g,f,e,d,c,b,a}
  always_comb begin
    w_seg = 7'h7F;
    case (w_nib)
      4'h0: w_seg = 7'h40;
      4'h1: w_seg = 7'h79;
      4'h2: w_seg = 7'h24;
      4'h3: w_seg = 7'h30;
      4'h4: w_seg = 7'h19;
      4'h5: w_seg = 7'h12;
      4'h6: w_seg = 7'h02;
      4'h7: w_seg = 7'h78;
      4'h8: w_seg = 7'h00;
      4'h9: w_seg = 7'h10;
      4'hA: w_seg = 7'h08;
      4'hB: w_seg = 7'h03;
      4'hC: w_seg = 7'h46;
      4'hD: w_seg = 7'h21;
      4'hE: w_seg = 7'h06;
      4'hF: w_seg = 7'h0E;
      default: w_seg = 7'h7F;
    endcase
  end

  logic [DIGITS-1:0] r_en;
  logic [6:0]        r_seg;
  logic              r_dp;

  // Register anode, segments and dp together so they change in the same cycle
  always_ff @(posedge clk_board) begin
    if (rst) begin
      r_en  <= '1;
      r_seg <= 7'h7F;
      r_dp  <= 1'b1;
    end else begin
      r_en  <= w_en_n;
      r_seg <= w_blank ? 7'h7F : w_seg;
      r_dp  <= ~w_dp_sel;
    end
  end

  assign cpu_tick     = r_tick;
  assign halted       = r_stop_db;
  assign tick_count   = r_tick_cnt;
  assign display_data = r_seg;
  assign display_dp   = r_dp;
  assign display_en   = r_en;

endmodule
`default_nettype wire

// File: tb/tb_board_io_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_board_io_ctrl
// Description : Self-checking bench for board_io_ctrl with a cycle-level
//               behavioural reference model and randomized stimulus.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_board_io_ctrl;

  localparam int D  = 8;
  localparam int S  = 4;
  localparam int C  = 5;
  localparam int DB = 8;

  logic          clk_board = 1'b0;
  logic          rst;
  logic          stop;
  logic          step_btn;
  logic          blank_lz;
  logic [4*D-1:0] in_data;
  logic [D-1:0]  dp_in;
  logic          cpu_tick;
  logic          halted;
  logic [31:0]   tick_count;
  logic [6:0]    display_data;
  logic          display_dp;
  logic [D-1:0]  display_en;

  board_io_ctrl #(
    .DIGITS  (D),
    .SCAN_DIV(S),
    .CPU_DIV (C),
    .DEB_CYC (DB)
  ) dut (
    .clk_board   (clk_board),
    .rst         (rst),
    .stop        (stop),
    .step_btn    (step_btn),
    .blank_lz    (blank_lz),
    .in_data     (in_data),
    .dp_in       (dp_in),
    .cpu_tick    (cpu_tick),
    .halted      (halted),
    .tick_count  (tick_count),
    .display_data(display_data),
    .display_dp  (display_dp),
    .display_en  (display_en)
  );

  always #5 clk_board = ~clk_board;

  int n_tests = 0;
  int n_fail  = 0;

  // reference model state
  int              m_n;
  logic [4*D-1:0]  m_snap_data;
  logic [D-1:0]    m_snap_dp;
  logic            m_snap_blank;
  logic            m_stop_lvl;
  logic            m_step_lvl;
  logic [DB-1:0]   m_stop_hist;
  logic [DB-1:0]   m_step_hist;
  int              m_stop_fill;
  int              m_step_fill;
  logic            m_step_rose;
  int              m_run;

  // expected outputs
  logic            e_tick;
  logic            e_halted;
  logic [31:0]     e_count;
  logic [6:0]      e_seg;
  logic            e_dp;
  logic [D-1:0]    e_en;

  function automatic logic [6:0] hexseg(input logic [3:0] h);
    case (h)
      4'h0: return 7'h40;  4'h1: return 7'h79;  4'h2: return 7'h24;  4'h3: return 7'h30;
      4'h4: return 7'h19;  4'h5: return 7'h12;  4'h6: return 7'h02;  4'h7: return 7'h78;
      4'h8: return 7'h00;  4'h9: return 7'h10;  4'hA: return 7'h08;  4'hB: return 7'h03;
      4'hC: return 7'h46;  4'hD: return 7'h21;  4'hE: return 7'h06;  4'hF: return 7'h0E;
      default: return 7'h7F;
    endcase
  endfunction

  // Advance the model by one rising edge using the inputs the DUT just sampled
  task automatic model_edge();
    logic old_halted;
    logic old_step;
    logic rose_now;
    int   idx;
    if (rst) begin
      m_n = 0; m_snap_data = '0; m_snap_dp = '0; m_snap_blank = 1'b0;
      m_stop_lvl = 1'b1; m_step_lvl = 1'b0;
      m_stop_hist = '0; m_step_hist = '0; m_stop_fill = 0; m_step_fill = 0;
      m_step_rose = 1'b0; m_run = 0;
      e_tick = 1'b0; e_halted = 1'b1; e_count = '0;
      e_seg = 7'h7F; e_dp = 1'b1; e_en = '1;
      return;
    end
    old_halted = m_stop_lvl;
    old_step   = m_step_lvl;
    // a level flips once the last DB samples all differ from it
    m_stop_hist = {m_stop_hist[DB-2:0], stop};
    if (m_stop_fill < DB) m_stop_fill++;
    if (m_stop_fill == DB && m_stop_hist == {DB{~m_stop_lvl}}) begin
      m_stop_lvl = ~m_stop_lvl; m_stop_fill = 0;
    end
    m_step_hist = {m_step_hist[DB-2:0], step_btn};
    if (m_step_fill < DB) m_step_fill++;
    if (m_step_fill == DB && m_step_hist == {DB{~m_step_lvl}}) begin
      m_step_lvl = ~m_step_lvl; m_step_fill = 0;
    end
    rose_now = m_step_lvl && !old_step;
    // free run: a tick every C edges of continuous running
    if (old_halted) m_run = 0;
    else m_run++;
    e_tick = (!old_halted && (m_run % C == 0)) ||
             (m_step_rose && old_halted && m_stop_lvl);
    m_step_rose = rose_now;
    if (e_tick) e_count = e_count + 32'd1;
    e_halted = m_stop_lvl;
    // display shows the digit that was selected before this edge
    idx  = (m_n / S) % D;
    e_en = ~(D'(1) << idx);
    e_dp = ~m_snap_dp[idx];
    if (m_snap_blank && idx > 0 && (m_snap_data >> (4*idx)) == '0) e_seg = 7'h7F;
    else e_seg = hexseg(m_snap_data[4*idx +: 4]);
    m_n++;
    if (m_n % (D*S) == 0) begin
      m_snap_data = in_data; m_snap_dp = dp_in; m_snap_blank = blank_lz;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_all();
    chk("cpu_tick",     32'(cpu_tick),     32'(e_tick));
    chk("halted",       32'(halted),       32'(e_halted));
    chk("tick_count",   tick_count,        e_count);
    chk("display_data", 32'(display_data), 32'(e_seg));
    chk("display_dp",   32'(display_dp),   32'(e_dp));
    chk("display_en",   32'(display_en),   32'(e_en));
  endtask

  task automatic cyc(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk_board);
      model_edge();
      @(negedge clk_board);
      check_all();
    end
  endtask

  initial begin
    logic [31:0] base;
    logic [31:0] rnd;
    int          sh;

    rst = 1'b1; stop = 1'b1; step_btn = 1'b0; blank_lz = 1'b0;
    in_data = '0; dp_in = '0;
    cyc(3);
    chk("rst_en",    32'(display_en),   32'hFF);
    chk("rst_seg",   32'(display_data), 32'h7F);
    chk("rst_halt",  32'(halted),       32'd1);
    chk("rst_count", tick_count,        32'd0);

    // release with stop low: halt drops after DB, then ticks every C
    rst = 1'b0; stop = 1'b0;
    cyc(DB + 3*C);
    chk("run_halted", 32'(halted),   32'd0);
    chk("run_tick3",  32'(cpu_tick), 32'd1);
    chk("run_count3", tick_count,    32'd3);

    // display patterns
    in_data = 32'h0000_01A3; blank_lz = 1'b1; dp_in = '0;
    cyc(3*D*S);
    blank_lz = 1'b0;
    cyc(2*D*S);
    cyc(5);
    in_data = 32'h89AB_CDEF;
    cyc(2*D*S + 3);
    in_data = '0; dp_in = 8'h01; blank_lz = 1'b1;
    cyc(2*D*S);

    // halt, two steps, one glitch
    stop = 1'b1;
    cyc(DB + 4);
    base = e_count;
    for (int p = 0; p < 2; p++) begin
      step_btn = 1'b1; cyc(2*DB);
      step_btn = 1'b0; cyc(2*DB);
    end
    step_btn = 1'b1; cyc(DB - 1);
    step_btn = 1'b0; cyc(2*DB);
    chk("step_count", tick_count, base + 32'd2);

    // randomized mix of halts, steps, glitches and display updates
    for (int it = 0; it < 120; it++) begin
      case ($urandom_range(0, 3))
        0: stop = ~stop;
        1: step_btn = ~step_btn;
        2: begin
          rnd = $urandom;
          sh  = $urandom_range(0, 8);
          in_data  = (sh == 8) ? 32'h0 : (rnd >> (4*sh));
          dp_in    = 8'($urandom);
          blank_lz = 1'($urandom);
        end
        default: ;
      endcase
      cyc($urandom_range(1, 3*DB));
    end

    // reset in the middle of a running frame
    stop = 1'b0; step_btn = 1'b0;
    cyc(2*DB + 3*C + 3);
    rst = 1'b1;
    cyc(1);
    chk("mrst_en",    32'(display_en), 32'hFF);
    chk("mrst_tick",  32'(cpu_tick),   32'd0);
    chk("mrst_count", tick_count,      32'd0);
    chk("mrst_halt",  32'(halted),     32'd1);
    rst = 1'b0;
    cyc(DB + 2*C + 5);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
